fetch_stage: RTL

- Instruction-fetch stage that sits directly upstream of the instruction memory and feeds the decode stage.
- Owns the 64-bit program counter and drives the memory's word address.
- Captures the returned 32-bit instruction into an IF/ID pipeline register.
- Handles sequential advance, stall hold, branch/jump redirect with bubble insertion, an end-of-memory guard and a fetched-instruction counter.

---
 rtl/fetch_stage_pkg.sv | 20 ++
 rtl/fetch_stage_if.sv | 31 +++
 rtl/fetch_stage_if_id_reg.sv | 60 ++++++
 rtl/fetch_stage.sv | 90 +++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared datapath widths, bubble encoding and reset PC for the fetch stage.
// fetch_stage.sv names FETCH_MISALIGN_TRAP_EN, which enables the misaligned-redirect pulse.
package fetch_stage_pkg;

    localparam int XLEN = 64;
    localparam int ILEN = 32;

    localparam logic [ILEN-1:0] NOP_INSTR_DEFAULT = 32'h0000_0013;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT  = 64'd0;

    typedef enum logic {
        RUN      = 1'b0,
        HALT_OOB = 1'b1
    } fetch_state_e;

    function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch stage bus: redirect/stall control, instruction memory port and IF/ID outputs.
interface fetch_stage_if;
    import fetch_stage_pkg::*;

    logic            stall;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_target;
    logic [XLEN-1:0] imem_addr;
    logic [ILEN-1:0] imem_data;
    logic [XLEN-1:0] pc;
    logic            if_id_valid;
    logic [XLEN-1:0] if_id_pc;
    logic [XLEN-1:0] if_id_pc_plus4;
    logic [ILEN-1:0] if_id_instr;
    logic            fetch_oob;
    logic [31:0]     fetch_count;
    logic            fetch_misaligned;

    modport master (
        input  stall, redirect_valid, redirect_target, imem_data,
        output imem_addr, pc, if_id_valid, if_id_pc, if_id_pc_plus4,
               if_id_instr, fetch_oob, fetch_count, fetch_misaligned
    );

    modport slave (
        output stall, redirect_valid, redirect_target, imem_data,
        input  imem_addr, pc, if_id_valid, if_id_pc, if_id_pc_plus4,
               if_id_instr, fetch_oob, fetch_count, fetch_misaligned
    );

endinterface

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register. Flush (bubble) wins over hold; hold wins over load.
module fetch_stage_if_id_reg
    import fetch_stage_pkg::*;
#(
    parameter logic [ILEN-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            hold_i,
    input  logic            flush_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic [ILEN-1:0] instr_i,
    output logic            valid_o,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] pc_plus4_o,
    output logic [ILEN-1:0] instr_o
);

    logic            valid_q, valid_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] pc4_q, pc4_d;
    logic [ILEN-1:0] instr_q, instr_d;

    always_comb begin
        valid_d = valid_q;
        pc_d    = pc_q;
        pc4_d   = pc4_q;
        instr_d = instr_q;
        if (flush_i) begin
            // Bubble keeps the last real PC pair visible to decode.
            valid_d = 1'b0;
            instr_d = NOP_INSTR;
        end else if (!hold_i) begin
            valid_d = 1'b1;
            pc_d    = pc_i;
            pc4_d   = pc_i + 64'd4;
            instr_d = instr_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            pc4_q   <= '0;
            instr_q <= NOP_INSTR;
        end else begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
            pc4_q   <= pc4_d;
            instr_q <= instr_d;
        end
    end

    assign valid_o    = valid_q;
    assign pc_o       = pc_q;
    assign pc_plus4_o = pc4_q;
    assign instr_o    = instr_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, next-PC mux, end-of-memory guard and fetch counter.
// Optional feature macro: FETCH_MISALIGN_TRAP_EN (one-cycle fetch_misaligned pulse).
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter int              MEM_WORDS = 501,
    parameter logic [ILEN-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    fetch_stage_if.master bus
);

    localparam logic [XLEN-3:0] MEM_LIMIT = (XLEN-2)'(MEM_WORDS);

    logic [XLEN-1:0] pc_q, pc_d;
    logic [31:0]     count_q, count_d;
    logic            flush;
    fetch_state_e    state;

    // HALT_OOB is a pure function of the PC, so no state register exists.
    assign state = (pc_q[XLEN-1:2] >= MEM_LIMIT) ? HALT_OOB : RUN;

    always_comb begin
        pc_d    = pc_q;
        count_d = count_q;
        flush   = 1'b0;
        if (bus.redirect_valid) begin
            pc_d  = align_word(bus.redirect_target);
            flush = 1'b1;
        end else if (!bus.stall) begin
            if (state == HALT_OOB) begin
                flush = 1'b1;
            end else begin
                pc_d    = pc_q + 64'd4;
                count_d = count_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= RESET_PC;
            count_q <= '0;
        end else begin
            pc_q    <= pc_d;
            count_q <= count_d;
        end
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    logic mis_q, mis_d;

    assign mis_d = bus.redirect_valid && (bus.redirect_target[1:0] != 2'b00);

    always_ff @(posedge clk) begin
        if (rst) begin
            mis_q <= 1'b0;
        end else begin
            mis_q <= mis_d;
        end
    end

    assign bus.fetch_misaligned = mis_q;
`else
    assign bus.fetch_misaligned = 1'b0;
`endif

    fetch_stage_if_id_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id (
        .clk        (clk),
        .rst        (rst),
        .hold_i     (bus.stall),
        .flush_i    (flush),
        .pc_i       (pc_q),
        .instr_i    (bus.imem_data),
        .valid_o    (bus.if_id_valid),
        .pc_o       (bus.if_id_pc),
        .pc_plus4_o (bus.if_id_pc_plus4),
        .instr_o    (bus.if_id_instr)
    );

    assign bus.pc          = pc_q;
    assign bus.imem_addr   = {2'b00, pc_q[XLEN-1:2]};
    assign bus.fetch_oob   = (state == HALT_OOB);
    assign bus.fetch_count = count_q;

endmodule
